// File: rtl/multy_table_seq.sv
// Builds the table k*val (k = 0..NUM_MULT-1) one entry per cycle with a single shared adder,
// then holds it under a valid/ready handshake until downstream takes it.
module multy_table_seq #(
  parameter int BW_XCOS  = 16,
  parameter int NUM_MULT = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BW_XCOS-1:0]           val_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [NUM_MULT*BW_XCOS-1:0]  tab_out
);

  localparam int IW = $clog2(NUM_MULT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MULT - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [BW_XCOS-1:0]   acc_q, acc_d;
  logic [BW_XCOS-1:0]   val_q, val_d;
  logic [BW_XCOS-1:0]   tab_q [NUM_MULT];
  logic [BW_XCOS-1:0]   tab_d [NUM_MULT];
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    val_d   = val_q;
    tab_d   = tab_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d   = val_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        // acc holds idx*val when entry idx is written; wraps modulo 2^BW_XCOS
        tab_d[idx_q] = acc_q;
        acc_d        = acc_q + val_q;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort leaves the table contents in place; only the handshake state is dropped.
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      val_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < NUM_MULT; k++) begin
        tab_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      val_q       <= val_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int k = 0; k < NUM_MULT; k++) begin
        tab_q[k] <= tab_d[k];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  for (genvar gi = 0; gi < NUM_MULT; gi++) begin : g_pack
    assign tab_out[gi*BW_XCOS +: BW_XCOS] = tab_q[gi];
  end

endmodule
